// File: rtl/sent_rx_crc_check_fast_if.sv
// Nibble capture and result bus of the SENT fast-channel CRC stage.
// crc_err_count exists only when SENT_RX_CRC_ERR_CNT_EN is defined.
interface sent_rx_crc_check_fast_if;
    logic        sync_detect;
    logic        nibble_strobe;
    logic [3:0]  nibble_in;
    logic        enable_crc_check_fast;
    logic        valid_data_fast;
    logic [23:0] data_fast;
    logic [3:0]  status_fast;
    logic        crc_error;
    logic        frame_error;
    logic        busy;
`ifdef SENT_RX_CRC_ERR_CNT_EN
    logic [7:0]  crc_err_count;
`endif

    modport master (
        output sync_detect, nibble_strobe, nibble_in, enable_crc_check_fast,
`ifdef SENT_RX_CRC_ERR_CNT_EN
        input  crc_err_count,
`endif
        input  valid_data_fast, data_fast, status_fast, crc_error, frame_error, busy
    );

    modport slave (
        input  sync_detect, nibble_strobe, nibble_in, enable_crc_check_fast,
`ifdef SENT_RX_CRC_ERR_CNT_EN
        output crc_err_count,
`endif
        output valid_data_fast, data_fast, status_fast, crc_error, frame_error, busy
    );
endinterface

// File: rtl/sent_rx_crc_check_fast.sv
// SENT fast-channel CRC stage: buffers one frame of nibbles and checks its CRC serially
// on a snapshot. Optional saturating CRC error counter under SENT_RX_CRC_ERR_CNT_EN.
module sent_rx_crc_check_fast #(
    parameter int         DATA_NIBBLES = 6,
    parameter logic [3:0] CRC_SEED     = 4'h5,
    parameter logic [3:0] CRC_POLY     = 4'hD
) (
    input logic                      clk_rx,
    input logic                      reset,
    sent_rx_crc_check_fast_if.slave  rx
);
    localparam int NB    = DATA_NIBBLES + 2;
    localparam int CNT_W = $clog2(NB + 1);
    localparam int IDX_W = $clog2(DATA_NIBBLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CHECK} state_e;

    state_e                 state_q, state_d;
    logic [NB-1:0][3:0]     buf_q, buf_d;
    logic [NB-1:0][3:0]     snap_q, snap_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [3:0]             crc_q, crc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic [23:0]            data_q, data_d;
    logic [3:0]             status_q, status_d;
    logic                   valid_q, valid_d;
    logic                   crc_err_q, crc_err_d;
    logic                   frame_err_q, frame_err_d;
    logic [3:0]             cur_nib;
    logic [23:0]            data_pack;

    // Multiply by x^4 modulo the CRC polynomial.
    function automatic logic [3:0] crc_step(input logic [3:0] x);
        logic [3:0] r;
        r = x;
        for (int b = 0; b < 4; b++) begin
            r = r[3] ? ({r[2:0], 1'b0} ^ CRC_POLY) : {r[2:0], 1'b0};
        end
        return r;
    endfunction

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (rx.sync_detect) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            if (rx.nibble_strobe) begin
                buf_d[0] = rx.nibble_in;
                cnt_d    = CNT_W'(1);
            end
        end else if (rx.nibble_strobe) begin
            if (cnt_q == CNT_W'(NB)) begin
                ovf_d = 1'b1;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if (cnt_q == CNT_W'(i)) buf_d[i] = rx.nibble_in;
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cur_nib   = '0;
        data_pack = '0;
        for (int i = 1; i <= DATA_NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) cur_nib = snap_q[i];
            data_pack[4*(DATA_NIBBLES-i) +: 4] = snap_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        crc_d       = crc_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        data_d      = data_q;
        status_d    = status_q;
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx.enable_crc_check_fast) begin
                    if (cnt_q == CNT_W'(NB) && !ovf_q) begin
                        state_d = S_CALC;
                        snap_d  = buf_q;
                        crc_d   = CRC_SEED;
                        idx_d   = IDX_W'(1);
                        busy_d  = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                crc_d = crc_step(crc_q) ^ cur_nib;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DATA_NIBBLES)) state_d = S_CHECK;
            end
            S_CHECK: begin
                // Final step is the zero-nibble augmentation.
                if (crc_step(crc_q) == snap_q[NB-1]) begin
                    valid_d  = 1'b1;
                    data_d   = data_pack;
                    status_d = snap_q[0];
                end else begin
                    crc_err_d = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the nibble buffer and snapshot are only a few flops, so they are reset with everything else rather than left undefined.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            snap_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            crc_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            status_q    <= '0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            crc_q       <= crc_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
            status_q    <= status_d;
            valid_q     <= valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SENT_RX_CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (crc_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign rx.crc_err_count = err_cnt_q;
`endif

    assign rx.valid_data_fast = valid_q;
    assign rx.data_fast       = data_q;
    assign rx.status_fast     = status_q;
    assign rx.crc_error       = crc_err_q;
    assign rx.frame_error     = frame_err_q;
    assign rx.busy            = busy_q;
endmodule

// File: tb/tb_sent_rx_crc_check_fast.sv
// Self-checking bench for sent_rx_crc_check_fast: 6-nibble and 3-nibble instances,
// CRC reference computed by polynomial long division over the whole frame.
module tb_sent_rx_crc_check_fast;
    logic clk_rx = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_rx = ~clk_rx;

    logic       sync_r = 1'b0, strobe_r = 1'b0, en_r = 1'b0, sel3 = 1'b0;
    logic [3:0] nib_r  = '0;
    int checks = 0;
    int errors = 0;

    sent_rx_crc_check_fast_if if6();
    sent_rx_crc_check_fast_if if3();

    assign if6.sync_detect           = sync_r;
    assign if6.nibble_strobe         = strobe_r;
    assign if6.nibble_in             = nib_r;
    assign if6.enable_crc_check_fast = en_r & ~sel3;
    assign if3.sync_detect           = sync_r;
    assign if3.nibble_strobe         = strobe_r;
    assign if3.nibble_in             = nib_r;
    assign if3.enable_crc_check_fast = en_r & sel3;

    sent_rx_crc_check_fast #(.DATA_NIBBLES(6)) u_dut6 (.clk_rx(clk_rx), .reset(reset), .rx(if6));
    sent_rx_crc_check_fast #(.DATA_NIBBLES(3)) u_dut3 (.clk_rx(clk_rx), .reset(reset), .rx(if3));

    logic        o_valid, o_crc_err, o_frame_err, o_busy;
    logic [23:0] o_data;
    logic [3:0]  o_status;
    assign o_valid     = sel3 ? if3.valid_data_fast : if6.valid_data_fast;
    assign o_crc_err   = sel3 ? if3.crc_error       : if6.crc_error;
    assign o_frame_err = sel3 ? if3.frame_error     : if6.frame_error;
    assign o_busy      = sel3 ? if3.busy            : if6.busy;
    assign o_data      = sel3 ? if3.data_fast       : if6.data_fast;
    assign o_status    = sel3 ? if3.status_fast     : if6.status_fast;
`ifdef SENT_RX_CRC_ERR_CNT_EN
    logic [7:0] o_cnt;
    assign o_cnt = sel3 ? if3.crc_err_count : if6.crc_err_count;
    int exp_cnt [2];
`endif

    logic [23:0] exp_data [2];
    logic [3:0]  exp_stat [2];
    int cyc, v_cnt, v_at, e_cnt, e_at, f_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: remainder of (seed . data nibbles . 0000) divided by x^4+x^3+x^2+1.
    function automatic logic [3:0] model_crc(input int nn, input logic [23:0] data);
        logic [35:0] msg;
        msg = 36'h5;
        for (int i = 0; i < nn; i++) msg = (msg << 4) | {32'd0, data[4*(nn-1-i) +: 4]};
        msg = msg << 4;
        for (int b = 35; b >= 4; b--) begin
            if (msg[b]) msg = msg ^ (36'h1D << (b - 4));
        end
        return msg[3:0];
    endfunction

    function automatic int cur_n();
        return sel3 ? 3 : 6;
    endfunction

    task automatic tick();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic tick_mon();
        tick();
        cyc++;
        if (o_valid === 1'b1) begin v_cnt++; if (v_at == 0) v_at = cyc; end
        if (o_crc_err === 1'b1) begin e_cnt++; if (e_at == 0) e_at = cyc; end
        if (o_frame_err === 1'b1) f_cnt++;
    endtask

    task automatic clr_mon();
        cyc = 0; v_cnt = 0; v_at = 0; e_cnt = 0; e_at = 0; f_cnt = 0;
    endtask

    task automatic strobe(input logic [3:0] v);
        strobe_r = 1'b1;
        nib_r    = v;
        tick_mon();
        strobe_r = 1'b0;
    endtask

    task automatic send_nibbles(input logic [3:0] st, input logic [23:0] data, input logic [3:0] crc);
        int nn;
        nn = cur_n();
        sync_r = 1'b1;
        tick_mon();
        sync_r = 1'b0;
        strobe(st);
        for (int i = 1; i <= nn; i++) strobe(data[4*(nn-i) +: 4]);
        strobe(crc);
    endtask

    task automatic start_check();
        clr_mon();
        en_r = 1'b1;
        tick();
        en_r = 1'b0;
        check("busy_after_enable", {31'd0, o_busy}, 1);
        check("no_frame_error", {31'd0, o_frame_err}, 0);
    endtask

    task automatic finish_check(input logic good, input logic [3:0] st, input logic [23:0] data);
        int nn, s;
        nn = cur_n();
        s  = int'(sel3);
        while (cyc < nn + 3) tick_mon();
        check("valid_count", v_cnt, good ? 1 : 0);
        check("valid_latency", v_at, good ? nn + 1 : 0);
        check("crc_error_count", e_cnt, good ? 0 : 1);
        check("crc_error_latency", e_at, good ? 0 : nn + 1);
        check("busy_done", {31'd0, o_busy}, 0);
        if (good) begin
            exp_data[s] = data;
            exp_stat[s] = st;
        end
        check("data_fast", {8'd0, o_data}, {8'd0, exp_data[s]});
        check("status_fast", {28'd0, o_status}, {28'd0, exp_stat[s]});
`ifdef SENT_RX_CRC_ERR_CNT_EN
        if (!good && exp_cnt[s] < 255) exp_cnt[s]++;
        check("crc_err_count", {24'd0, o_cnt}, exp_cnt[s]);
`endif
    endtask

    task automatic run_frame(input logic [3:0] st, input logic [23:0] data, input logic [3:0] crc);
        send_nibbles(st, data, crc);
        start_check();
        finish_check(crc == model_crc(cur_n(), data), st, data);
    endtask

    task automatic reset_expect();
        for (int s = 0; s < 2; s++) begin
            exp_data[s] = '0;
            exp_stat[s] = '0;
`ifdef SENT_RX_CRC_ERR_CNT_EN
            exp_cnt[s] = 0;
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d, db;
        logic [3:0]  st, stb, c;
        logic [31:0] mask;
        int nn;

        reset_expect();
        clr_mon();
        repeat (3) tick();
        check("rst_valid", {31'd0, if6.valid_data_fast}, 0);
        check("rst_crc_error", {31'd0, if6.crc_error}, 0);
        check("rst_frame_error", {31'd0, if6.frame_error}, 0);
        check("rst_busy", {31'd0, if6.busy}, 0);
        check("rst_data", {8'd0, if6.data_fast}, 0);
        check("rst_status", {28'd0, if6.status_fast}, 0);
        check("rst_busy3", {31'd0, if3.busy}, 0);
        reset = 1'b0;
        tick();

        // All-zero frame with its correct CRC of 5.
        sel3 = 1'b0;
        run_frame(4'h0, 24'h0, 4'h5);
        check("t1_latency_7", v_at, 7);

        // Good random frame, then the zero frame with CRC 4: error, data kept.
        d  = 24'($urandom);
        st = 4'($urandom_range(0, 15));
        run_frame(st, d, model_crc(6, d));
        run_frame(4'h0, 24'h0, 4'h4);
        check("t2_err_latency_7", e_at, 7);
        check("t2_data_kept", {8'd0, o_data}, {8'd0, d});

        // Three-nibble instance.
        sel3 = 1'b1;
        run_frame(4'h0, 24'h0, 4'h9);
        check("t3_latency_4", v_at, 4);
        run_frame(4'h0, 24'h0, 4'h5);
        check("t3_err_latency_4", e_at, 4);

        // Randomised frames on both instances, about a quarter with a corrupted CRC.
        for (int k = 0; k < 24; k++) begin
            sel3 = k[0];
            nn   = cur_n();
            mask = (32'h1 << (4 * nn)) - 32'h1;
            d    = 24'($urandom & mask);
            st   = 4'($urandom_range(0, 15));
            c    = model_crc(nn, d);
            if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
            run_frame(st, d, c);
        end

        // Short frame, then overflowed frame: both give frame_error only.
        sel3 = 1'b0;
        sync_r = 1'b1; tick(); sync_r = 1'b0;
        for (int i = 0; i < 5; i++) strobe(4'(i + 1));
        clr_mon();
        en_r = 1'b1; tick(); en_r = 1'b0;
        check("short_frame_error", {31'd0, o_frame_err}, 1);
        check("short_busy", {31'd0, o_busy}, 0);
        tick();
        check("short_frame_error_pulse", {31'd0, o_frame_err}, 0);
        sync_r = 1'b1; tick(); sync_r = 1'b0;
        for (int i = 0; i < 9; i++) strobe(4'(i));
        clr_mon();
        en_r = 1'b1; tick(); en_r = 1'b0;
        check("ovf_frame_error", {31'd0, o_frame_err}, 1);
        check("ovf_busy", {31'd0, o_busy}, 0);
        repeat (9) tick_mon();
        check("ovf_no_result", v_cnt + e_cnt, 0);
        check("ovf_data_kept", {8'd0, o_data}, {8'd0, exp_data[0]});

        // Re-enable during CALC plus a new frame arriving mid-check.
        d   = 24'($urandom);
        st  = 4'($urandom_range(0, 15));
        db  = 24'($urandom);
        stb = 4'($urandom_range(0, 15));
        send_nibbles(st, d, model_crc(6, d));
        start_check();
        tick_mon();
        en_r = 1'b1; tick_mon(); en_r = 1'b0;
        sync_r = 1'b1; strobe_r = 1'b1; nib_r = stb;
        tick_mon();
        sync_r = 1'b0; strobe_r = 1'b0;
        for (int i = 1; i <= 6; i++) strobe(db[4*(6-i) +: 4]);
        strobe(model_crc(6, db));
        finish_check(1'b1, st, d);
        start_check();
        finish_check(1'b1, stb, db);

        // Reset while calculating: outputs clear at once, no late pulse.
        d  = 24'($urandom) | 24'h1;
        st = 4'($urandom_range(1, 15));
        send_nibbles(st, d, model_crc(6, d));
        start_check();
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, if6.busy}, 0);
        check("mid_rst_data", {8'd0, if6.data_fast}, 0);
        check("mid_rst_status", {28'd0, if6.status_fast}, 0);
        check("mid_rst_valid", {31'd0, if6.valid_data_fast}, 0);
        check("mid_rst_crc_error", {31'd0, if6.crc_error}, 0);
        tick();
        reset = 1'b0;
        reset_expect();
        clr_mon();
        repeat (10) tick_mon();
        check("post_rst_no_pulse", v_cnt + e_cnt + f_cnt, 0);
        clr_mon();
        en_r = 1'b1; tick(); en_r = 1'b0;
        check("post_rst_buffer_empty", {31'd0, o_frame_err}, 1);
        tick();

`ifdef SENT_RX_CRC_ERR_CNT_EN
        // Repeated bad checks of the same buffered frame saturate the counter.
        send_nibbles(4'h0, 24'h0, 4'h4);
        for (int k = 0; k < 300; k++) begin
            start_check();
            finish_check(1'b0, 4'h0, 24'h0);
        end
        check("err_count_saturated", {24'd0, o_cnt}, 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sent_rx_crc_check_fast.md
Name: sent_rx_crc_check_fast

Overview:
Fast-channel CRC stage of the SENT receiver, directly downstream of the receiver control block.
- Buffers nibbles decoded by the pulse check block for one frame: status, DATA_NIBBLES data nibbles, then CRC.
- On the one-shot enable_crc_check_fast pulse from the control block, computes the SENT 4-bit CRC serially over the data nibbles.
- Publishes data_fast / valid_data_fast on a match; pulses crc_error on a mismatch.

Parameters:
DATA_NIBBLES, 6, data nibbles per fast frame; legal 3..6.
CRC_SEED, 4'h5, CRC initial value.
CRC_POLY, 4'hD, low 4 bits of x^4+x^3+x^2+1.

Ports:
clk_rx  input  1  receive clock; all logic on rising edge
reset  input  1  asynchronous, active-high
sync_detect  input  1  one-cycle pulse; new frame, clears nibble buffer
nibble_strobe  input  1  one-cycle pulse; nibble_in valid
nibble_in  input  4  decoded nibble value
enable_crc_check_fast  input  1  start check; high for exactly one rising edge
valid_data_fast  output  1  one-cycle pulse; data_fast/status_fast updated, CRC good
data_fast  output  24  data nibbles, right-aligned
status_fast  output  4  status nibble of last good frame
crc_error  output  1  one-cycle pulse; CRC mismatch
frame_error  output  1  one-cycle pulse; wrong nibble count at enable
busy  output  1  high while checking

Behaviour:
Reset: all outputs 0; buffer, count and overflow cleared; FSM enters IDLE.

Capture (independent of FSM):
- sync_detect clears count and overflow.
- Each nibble_strobe stores nibble_in at index count, then increments count.
- Index 0 is status, 1..N are data, N+1 is CRC (N = DATA_NIBBLES).
- A strobe when count = N+2 sets overflow and is not stored.
- sync_detect and nibble_strobe on the same edge: the nibble is stored at index 0 and count becomes 1.

FSM states: IDLE, CALC, CHECK.
- IDLE -> CALC on enable with count = N+2 and overflow = 0.
  - On that edge: snapshot buffer into a working copy, crc <= CRC_SEED, idx <= 1, busy <= 1.
- Enable in IDLE with a wrong count or overflow set: frame_error pulses on the next cycle and the FSM stays in IDLE.
- Enable while busy is ignored.
- CALC: each edge performs crc <= T(crc) XOR data[idx], idx++. After processing idx = N, go to CHECK.
- CHECK: one edge. Compare T(crc) with the snapshot CRC nibble (the zero-nibble augmentation).
  - On match: valid_data_fast = 1, data_fast <= packed data, status_fast <= status.
  - On mismatch: crc_error = 1; data_fast and status_fast keep their last good values.
  - busy <= 0; return to IDLE.
- T(x): repeat 4 times: msb = x[3]; x = {x[2:0],0}; if msb then x ^= CRC_POLY.

Latency: enable sampled at edge E -> result pulse registered at edge E+N+1 (7 clocks for N = 6).

Packing: D1 (first data nibble) at bits [4N-1:4N-4], DN at bits [3:0], bits above 4N are 0.

Simultaneous and mid-operation events:
- sync_detect or strobes during CALC/CHECK affect only the capture buffer. The calculation uses the snapshot, so the next frame may start arriving while the check runs.
- Reset mid-check: aborts immediately; no pulse is produced.

Optional Feature:
Macro SENT_RX_CRC_ERR_CNT_EN.
- Defined: adds output crc_err_count [7:0].
  - Increments on each crc_error pulse and saturates at 8'hFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. N=6: sync, strobes status 0, data 0,0,0,0,0,0, CRC 5, then enable -> valid_data_fast exactly 7 clocks after enable, data_fast = 24'h000000, crc_error = 0.
2. Same frame with CRC nibble 4 -> crc_error single pulse 7 clocks after enable, no valid; data_fast unchanged; with SENT_RX_CRC_ERR_CNT_EN, crc_err_count = 1.
3. DATA_NIBBLES=3: data 0,0,0, CRC 9 -> valid after 4 clocks, data_fast = 24'h000000; same frame with CRC 5 -> crc_error.
4. Only 5 of 8 nibbles strobed before enable -> frame_error pulse next cycle, busy stays 0; then 9 strobes (overflow) + enable -> frame_error.
5. Enable re-pulsed during CALC plus sync_detect and new nibbles mid-check -> first result still correct for the snapshot, second enable ignored; following frame checks correctly.
6. Reset asserted during CALC -> all outputs 0 immediately, no valid/crc_error pulse after release; 300 crc_error frames with SENT_RX_CRC_ERR_CNT_EN -> count holds at 8'hFF.
